// File: rtl/eth_tx_frame_gen.sv
// Ethernet II test-frame generator for the MAC TX byte interface.
// Emits dst/src/type, sequence-numbered payload and in-line CRC-32 FCS.
module eth_tx_frame_gen #(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        i_mac_tx_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_cont,
    input  logic [10:0] i_payload_len,
    input  logic [47:0] i_dst_mac,
    input  logic [47:0] i_src_mac,
    input  logic [15:0] i_ethertype,
    output logic [7:0]  o_mac_tx_data,
    output logic        o_mac_tx_valid,
    output logic        o_mac_tx_sof,
    output logic        o_mac_tx_eof,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [31:0] o_frame_cnt
);

    localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_LAST =
        11'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_FCS,
        S_IFG
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [10:0]   r_idx;
    logic [10:0]   w_idx_nx;
    logic [111:0]  r_hdr;
    logic [10:0]   r_n;
    logic [31:0]   r_seq;
    logic [31:0]   r_crc;
    logic [10:0]   w_len;
    logic [7:0]    w_byte;
    logic [7:0]    w_seq_byte;
    logic [7:0]    w_fcs_byte;
    logic          w_valid;
    logic          w_sof;
    logic          w_eof;
    logic          w_launch;
    logic          w_crc_en;

    // Reflected CRC-32, one data byte per call, LSB first.
    function automatic logic [31:0] crc_next(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] v;
        v = c;
        for (int b = 0; b < 8; b++)
            v = (v >> 1) ^ (32'hEDB88320 & {32{v[0] ^ d[b]}});
        return v;
    endfunction

    always_comb begin
        w_len = i_payload_len;
        if (i_payload_len < MIN_L)
            w_len = MIN_L;
        else if (i_payload_len > MAX_L)
            w_len = MAX_L;
    end

    always_comb begin
        w_seq_byte = r_seq[31:24];
        unique case (r_idx[1:0])
            2'd0: w_seq_byte = r_seq[31:24];
            2'd1: w_seq_byte = r_seq[23:16];
            2'd2: w_seq_byte = r_seq[15:8];
            2'd3: w_seq_byte = r_seq[7:0];
            default: w_seq_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_fcs_byte = ~r_crc[7:0];
        unique case (r_idx[1:0])
            2'd0: w_fcs_byte = ~r_crc[7:0];
            2'd1: w_fcs_byte = ~r_crc[15:8];
            2'd2: w_fcs_byte = ~r_crc[23:16];
            2'd3: w_fcs_byte = ~r_crc[31:24];
            default: w_fcs_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx + 11'd1;
        w_byte     = 8'h00;
        w_valid    = 1'b0;
        w_sof      = 1'b0;
        w_eof      = 1'b0;
        w_launch   = 1'b0;
        w_crc_en   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_idx_nx = 11'd0;
                // busy still high on the first IDLE cycle after IFG
                if ((i_start || i_cont) && !o_busy) begin
                    w_state_nx = S_HDR;
                    w_launch   = 1'b1;
                end
            end
            S_HDR: begin
                w_valid  = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = r_hdr[111:104];
                w_sof    = (r_idx == 11'd0);
                if (r_idx == 11'd13) begin
                    w_state_nx = S_PAY;
                    w_idx_nx   = 11'd0;
                end
            end
            S_PAY: begin
                w_valid  = 1'b1;
                w_crc_en = 1'b1;
                if (r_idx < 11'd4)
                    w_byte = w_seq_byte;
                else
                    w_byte = r_seq[7:0] + r_idx[7:0];
                if (r_idx == r_n - 11'd1) begin
                    w_state_nx = S_FCS;
                    w_idx_nx   = 11'd0;
                end
            end
            S_FCS: begin
                w_valid = 1'b1;
                w_byte  = w_fcs_byte;
                if (r_idx == 11'd3) begin
                    w_eof    = 1'b1;
                    w_idx_nx = 11'd0;
                    if (IFG_CYCLES > 0) begin
                        w_state_nx = S_IFG;
                    end else if (i_cont) begin
                        w_state_nx = S_HDR;
                        w_launch   = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_IFG: begin
                if (r_idx == IFG_LAST) begin
                    w_idx_nx = 11'd0;
                    if (i_cont) begin
                        w_state_nx = S_HDR;
                        w_launch   = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = 11'd0;
            end
        endcase
    end

    always_ff @(posedge i_mac_tx_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_idx          <= 11'd0;
            r_hdr          <= '0;
            r_n            <= 11'd0;
            r_seq          <= 32'd0;
            r_crc          <= 32'd0;
            o_mac_tx_data  <= 8'h00;
            o_mac_tx_valid <= 1'b0;
            o_mac_tx_sof   <= 1'b0;
            o_mac_tx_eof   <= 1'b0;
            o_busy         <= 1'b0;
            o_frame_done   <= 1'b0;
            o_frame_cnt    <= 32'd0;
        end else begin
            r_state        <= w_state_nx;
            r_idx          <= w_idx_nx;
            o_mac_tx_data  <= w_byte;
            o_mac_tx_valid <= w_valid;
            o_mac_tx_sof   <= w_sof;
            o_mac_tx_eof   <= w_eof;
            o_busy         <= (r_state != S_IDLE);
            o_frame_done   <= o_mac_tx_eof;
            if (w_launch) begin
                r_hdr <= {i_dst_mac, i_src_mac, i_ethertype};
                r_n   <= w_len;
                r_crc <= 32'hFFFF_FFFF;
            end else begin
                if (r_state == S_HDR)
                    r_hdr <= r_hdr << 8;
                if (w_crc_en)
                    r_crc <= crc_next(r_crc, w_byte);
            end
            if (w_eof) begin
                r_seq       <= r_seq + 32'd1;
                o_frame_cnt <= o_frame_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Self-checking bench for eth_tx_frame_gen against a byte-list frame model.
// A second instance with IFG_CYCLES=0 covers back-to-back streaming.
module tb_eth_tx_frame_gen;

    logic        clk = 1'b0;
    always #4 clk = ~clk;

    logic        rst, start, cont;
    logic [10:0] plen;
    logic [47:0] dst, src;
    logic [15:0] etype;
    logic [7:0]  data, data0;
    logic        valid, sof, eof, busy, done;
    logic        valid0, sof0, eof0, busy0, done0;
    logic [31:0] fcnt, fcnt0;

    eth_tx_frame_gen dut (
        .i_mac_tx_clk(clk), .i_rst(rst), .i_start(start), .i_cont(cont),
        .i_payload_len(plen), .i_dst_mac(dst), .i_src_mac(src),
        .i_ethertype(etype), .o_mac_tx_data(data), .o_mac_tx_valid(valid),
        .o_mac_tx_sof(sof), .o_mac_tx_eof(eof), .o_busy(busy),
        .o_frame_done(done), .o_frame_cnt(fcnt)
    );

    eth_tx_frame_gen #(.IFG_CYCLES(0)) dut0 (
        .i_mac_tx_clk(clk), .i_rst(rst), .i_start(start), .i_cont(cont),
        .i_payload_len(plen), .i_dst_mac(dst), .i_src_mac(src),
        .i_ethertype(etype), .o_mac_tx_data(data0), .o_mac_tx_valid(valid0),
        .o_mac_tx_sof(sof0), .o_mac_tx_eof(eof0), .o_busy(busy0),
        .o_frame_done(done0), .o_frame_cnt(fcnt0)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] tbl [256];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  cur[$];
    int          rx_len[$];
    int          gaps[$];
    int          mon_err = 0;
    int          done_cnt = 0;
    int          gap = 0;
    bit          in_frame = 0;
    bit          prev_eof = 0;
    logic [31:0] exp_seq = 0;

    // Frame capture: bytes, lengths, idle gap before each sof, protocol errors.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 0;
            cur.delete();
            prev_eof = 0;
        end else begin
            if (done && !prev_eof) mon_err++;
            if (done) done_cnt++;
            if (valid) begin
                if (sof && eof) mon_err++;
                if (sof) begin
                    if (in_frame) mon_err++;
                    in_frame = 1;
                    cur.delete();
                    gaps.push_back(gap);
                end else if (!in_frame) begin
                    mon_err++;
                end
                cur.push_back(data);
                if (eof) begin
                    foreach (cur[k]) rx_q.push_back(cur[k]);
                    rx_len.push_back(cur.size());
                    in_frame = 0;
                    gap = 0;
                end
            end else begin
                if (in_frame) mon_err++;
                if (data !== 8'h00) mon_err++;
                gap++;
            end
            prev_eof = eof;
        end
    end

    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
        return (c >> 8) ^ tbl[c[7:0] ^ b];
    endfunction

    task automatic add_exp(input int len, input logic [47:0] d,
                           input logic [47:0] s, input logic [15:0] t,
                           input logic [31:0] sq);
        int n;
        logic [7:0] f[$];
        logic [31:0] c;
        n = (len < 46) ? 46 : ((len > 1500) ? 1500 : len);
        for (int i = 0; i < 6; i++) f.push_back(8'(d >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) f.push_back(8'(s >> (40 - 8 * i)));
        f.push_back(t[15:8]);
        f.push_back(t[7:0]);
        for (int i = 0; i < n; i++) begin
            if (i < 4) f.push_back(8'(sq >> (24 - 8 * i)));
            else f.push_back(8'(int'(sq[7:0]) + i));
        end
        c = 32'hFFFF_FFFF;
        foreach (f[k]) c = crc_upd(c, f[k]);
        c = ~c;
        for (int j = 0; j < 4; j++) f.push_back(8'(c >> (8 * j)));
        foreach (f[k]) exp_q.push_back(f[k]);
    endtask

    function automatic int first_diff();
        int m;
        m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            if (rx_q[i] !== exp_q[i]) return i;
        if (rx_q.size() != exp_q.size()) return m;
        return -1;
    endfunction

    function automatic logic [31:0] rx_word(int off);
        if (rx_q.size() < off + 4) return 32'hDEAD_0000;
        return {rx_q[off], rx_q[off+1], rx_q[off+2], rx_q[off+3]};
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        rx_len.delete();
        gaps.delete();
        exp_q.delete();
        mon_err = 0;
        done_cnt = 0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_len.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (rx_len.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while ((busy || busy0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = !busy && !busy0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic rand_cfg(input int lo, input int hi);
        plen  = 11'($urandom_range(hi, lo));
        dst   = 48'({$urandom(), $urandom()});
        src   = 48'({$urandom(), $urandom()});
        etype = 16'($urandom());
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 0 || sof !== 0 || eof !== 0 || data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx got v=%b s=%b e=%b d=%h want 0", valid, sof, eof, data);
        end
        checks++;
        if (busy !== 0 || done !== 0 || fcnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_status got busy=%b done=%b cnt=%0d want 0", busy, done, fcnt);
        end
        rst = 0;
        exp_seq = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int d;
        logic [31:0] c;
        logic [47:0] pw;
        clear_mon();
        plen = 11'd46;
        dst = '1;
        src = 48'h02_00_00_00_00_01;
        etype = 16'h88B5;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (valid !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL basic_latch_cycle got v=%b busy=%b want 0 0", valid, busy);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1 || sof !== 1 || busy !== 1 || data !== 8'hFF) begin
            failures++;
            $display("FAIL basic_sof got v=%b s=%b busy=%b d=%h want 1 1 1 ff",
                     valid, sof, busy, data);
        end
        add_exp(46, dst, src, etype, exp_seq);
        wait_frames(1, 300, ok);
        checks++;
        if (!ok || rx_len[0] != 64) begin
            failures++;
            $display("FAIL basic_len got frames=%0d len=%0d want 1 64", rx_len.size(),
                     rx_len.size() > 0 ? rx_len[0] : -1);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL basic_bytes first diff at %0d", d);
        end
        c = 32'hFFFF_FFFF;
        foreach (rx_q[k]) c = crc_upd(c, rx_q[k]);
        checks++;
        if (c !== 32'hDEBB20E3) begin
            failures++;
            $display("FAIL basic_residue got %h want debb20e3", c);
        end
        pw = (rx_q.size() >= 20) ? {rx_word(14), rx_q[18], rx_q[19]} : '1;
        checks++;
        if (pw !== 48'h00_00_00_00_04_05) begin
            failures++;
            $display("FAIL basic_payload got %h want 000000000405", pw);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok || fcnt !== 32'd1 || done_cnt != 1 || mon_err != 0) begin
            failures++;
            $display("FAIL basic_status got cnt=%0d done=%0d err=%0d want 1 1 0",
                     fcnt, done_cnt, mon_err);
        end
        exp_seq++;
    endtask

    task automatic test_clamp();
        bit ok;
        int lens[2] = '{10, 2000};
        int want[2] = '{64, 1518};
        for (int t = 0; t < 2; t++) begin
            clear_mon();
            plen = 11'(lens[t]);
            add_exp(lens[t], dst, src, etype, exp_seq);
            pulse_start();
            wait_frames(1, 2000, ok);
            checks++;
            if (!ok || rx_len[0] != want[t] || first_diff() != -1) begin
                failures++;
                $display("FAIL clamp_%0d got len=%0d diff=%0d want len=%0d", lens[t],
                         rx_len.size() > 0 ? rx_len[0] : -1, first_diff(), want[t]);
            end
            wait_idle(100, ok);
            exp_seq++;
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int t = 0; t < 12; t++) begin
            clear_mon();
            rand_cfg(0, 1700);
            add_exp(int'(plen), dst, src, etype, exp_seq);
            pulse_start();
            wait_frames(1, 2000, ok);
            checks++;
            if (!ok || first_diff() != -1 || mon_err != 0) begin
                failures++;
                $display("FAIL random_%0d len=%0d got diff=%0d err=%0d want -1 0",
                         t, plen, first_diff(), mon_err);
            end
            wait_idle(100, ok);
            exp_seq++;
        end
    endtask

    task automatic test_cont();
        bit ok;
        int k = 0;
        logic [31:0] base;
        clear_mon();
        rand_cfg(40, 100);
        base = fcnt;
        for (int i = 0; i < 3; i++)
            add_exp(int'(plen), dst, src, etype, exp_seq + 32'(i));
        @(negedge clk);
        cont = 1;
        while (!(rx_len.size() == 2 && in_frame) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        cont = 0;
        wait_frames(3, 500, ok);
        wait_idle(200, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (rx_len.size() != 3 || first_diff() != -1) begin
            failures++;
            $display("FAIL cont_frames got n=%0d diff=%0d want 3 -1",
                     rx_len.size(), first_diff());
        end
        checks++;
        if (gaps.size() < 3 || gaps[1] != 12 || gaps[2] != 12) begin
            failures++;
            $display("FAIL cont_ifg got %0d %0d want 12 12",
                     gaps.size() > 1 ? gaps[1] : -1, gaps.size() > 2 ? gaps[2] : -1);
        end
        checks++;
        if (rx_word(2 * (int'(plen) < 46 ? 64 : int'(plen) + 18) + 14) !== exp_seq + 2) begin
            failures++;
            $display("FAIL cont_seq3 got %h want %h",
                     rx_word(2 * (int'(plen) < 46 ? 64 : int'(plen) + 18) + 14), exp_seq + 2);
        end
        checks++;
        if (fcnt - base !== 32'd3 || done_cnt != 3 || mon_err != 0) begin
            failures++;
            $display("FAIL cont_count got dcnt=%0d done=%0d err=%0d want 3 3 0",
                     fcnt - base, done_cnt, mon_err);
        end
        exp_seq += 3;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int k = 0;
        logic [31:0] base;
        clear_mon();
        rand_cfg(60, 200);
        base = fcnt;
        add_exp(int'(plen), dst, src, etype, exp_seq);
        pulse_start();
        while (cur.size() < 30 && k < 200) begin
            @(negedge clk);
            k++;
        end
        dst = ~dst;
        plen = 11'd1000;
        pulse_start();
        wait_frames(1, 400, ok);
        repeat (3) @(negedge clk);
        pulse_start();
        wait_idle(200, ok);
        repeat (30) @(negedge clk);
        checks++;
        if (rx_len.size() != 1 || in_frame || fcnt - base !== 32'd1) begin
            failures++;
            $display("FAIL ignore_start got frames=%0d dcnt=%0d want 1 1",
                     rx_len.size(), fcnt - base);
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL config_hold first diff at %0d want -1", first_diff());
        end
        exp_seq++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int k;
        wait_idle(3000, ok);
        rand_cfg(46, 60);
        @(negedge clk);
        cont = 1;
        for (int f = 0; f < 2; f++) begin
            k = 0;
            while (!eof0 && k < 500) begin
                @(negedge clk);
                k++;
            end
            @(negedge clk);
            checks++;
            if (valid0 !== 1 || sof0 !== 1) begin
                failures++;
                $display("FAIL b2b_sof_%0d got v=%b s=%b want 1 1", f, valid0, sof0);
            end
        end
        cont = 0;
        wait_idle(500, ok);
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp_seq = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        clear_mon();
        rand_cfg(100, 100);
        pulse_start();
        while (cur.size() < 35 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (valid !== 0 || eof !== 0 || busy !== 0 || fcnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid got v=%b e=%b busy=%b cnt=%0d want 0 0 0 0",
                     valid, eof, busy, fcnt);
        end
        rst = 0;
        exp_seq = 0;
        clear_mon();
        rand_cfg(0, 300);
        add_exp(int'(plen), dst, src, etype, exp_seq);
        pulse_start();
        wait_frames(1, 600, ok);
        wait_idle(100, ok);
        checks++;
        if (rx_word(14) !== 32'd0 || first_diff() != -1 || fcnt !== 32'd1) begin
            failures++;
            $display("FAIL reset_seq got seq=%h diff=%0d cnt=%0d want 0 -1 1",
                     rx_word(14), first_diff(), fcnt);
        end
    endtask

    initial begin
        logic [31:0] c;
        rst = 1;
        start = 0;
        cont = 0;
        plen = '0;
        dst = '0;
        src = '0;
        etype = '0;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            tbl[n] = c;
        end
        test_reset();
        test_basic();
        test_clamp();
        test_random();
        test_cont();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
